// File: rtl/branch_update_queue.sv
// In-order queue of predicted branches between fetch and execute; the oldest entry is
// resolved, the BHT training update is registered, and a misprediction squashes younger entries.
module branch_update_queue #(
   parameter int IDX_W = 5,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic                         push_valid,
   input  logic [IDX_W-1:0]             push_idx,
   input  logic                         push_pred,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       occupancy,
   input  logic                         resolve_valid,
   input  logic                         resolve_taken,
   input  logic                         flush,
   output logic                         bht_en,
   output logic [IDX_W-1:0]             bht_write_addr,
   output logic                         bht_was_taken,
   output logic                         mispredict,
   output logic [CNT_W-1:0]             mispredict_count,
   output logic                         underflow_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [IDX_W-1:0] idx_mem  [DEPTH];
   logic             pred_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;

   logic resolve_acc;
   logic mispredict_now;
   logic push_acc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      return (&val) ? val : val + CNT_W'(1);
   endfunction

   assign full      = (occ == OCC_W'(DEPTH));
   assign empty     = (occ == '0);
   assign occupancy = occ;

   assign resolve_acc    = resolve_valid & ~empty;
   assign mispredict_now = resolve_acc & (resolve_taken != pred_mem[rd_ptr]);
   // A resolve in the same cycle frees the head slot, so a full queue can still accept a push.
   assign push_acc = push_valid & (~full | resolve_acc) & ~flush & ~mispredict_now;

   // Entry storage carries no reset; validity is tracked solely by the pointers and occupancy.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         idx_mem[wr_ptr]  <= push_idx;
         pred_mem[wr_ptr] <= push_pred;
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush || mispredict_now) begin
         rd_ptr <= wr_ptr;
         occ    <= '0;
      end else begin
         if (push_acc)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (resolve_acc)
            rd_ptr <= rd_ptr + PTR_W'(1);
         occ <= occ + OCC_W'(push_acc) - OCC_W'(resolve_acc);
      end
   end

   // Resolve stage: BHT update and mispredict flag appear one cycle after the accepted resolve.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         bht_en           <= 1'b0;
         bht_write_addr   <= '0;
         bht_was_taken    <= 1'b0;
         mispredict       <= 1'b0;
         mispredict_count <= '0;
         underflow_err    <= 1'b0;
      end else begin
         bht_en     <= resolve_acc;
         mispredict <= mispredict_now;
         if (resolve_acc) begin
            bht_write_addr <= idx_mem[rd_ptr];
            bht_was_taken  <= resolve_taken;
         end
         if (mispredict_now)
            mispredict_count <= sat_inc(mispredict_count);
         if (resolve_valid && empty)
            underflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench for branch_update_queue: a reference queue model predicts each BHT update,
// and a second instance with a 2-bit counter exercises mispredict-count saturation.
module tb_branch_update_queue;

   localparam int IDX_W = 5;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             pred;
   } ent_t;

   typedef struct packed {
      logic [IDX_W-1:0] addr;
      logic             taken;
      logic             mis;
   } exp_t;

   logic             clk = 1'b0;
   logic             arst_n;
   logic             push_valid;
   logic [IDX_W-1:0] push_idx;
   logic             push_pred;
   logic             resolve_valid;
   logic             resolve_taken;
   logic             flush;

   logic             full, empty, bht_en, bht_was_taken, mispredict, underflow_err;
   logic [2:0]       occupancy;
   logic [IDX_W-1:0] bht_write_addr;
   logic [15:0]      mispredict_count;

   logic             s_full, s_empty, s_bht_en, s_bht_was_taken, s_mispredict, s_underflow_err;
   logic [2:0]       s_occupancy;
   logic [IDX_W-1:0] s_bht_write_addr;
   logic [1:0]       s_mispredict_count;

   ent_t  mq[$];
   exp_t  exp_q[$];
   logic  m_under;
   int    m_cnt16;
   int    m_cnt2;
   int    n_chk  = 0;
   int    n_pass = 0;

   always #5 clk = ~clk;

   branch_update_queue #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .arst_n(arst_n),
      .push_valid(push_valid), .push_idx(push_idx), .push_pred(push_pred),
      .full(full), .empty(empty), .occupancy(occupancy),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
      .bht_en(bht_en), .bht_write_addr(bht_write_addr), .bht_was_taken(bht_was_taken),
      .mispredict(mispredict), .mispredict_count(mispredict_count), .underflow_err(underflow_err)
   );

   branch_update_queue #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
      .clk(clk), .arst_n(arst_n),
      .push_valid(push_valid), .push_idx(push_idx), .push_pred(push_pred),
      .full(s_full), .empty(s_empty), .occupancy(s_occupancy),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
      .bht_en(s_bht_en), .bht_write_addr(s_bht_write_addr), .bht_was_taken(s_bht_was_taken),
      .mispredict(s_mispredict), .mispredict_count(s_mispredict_count), .underflow_err(s_underflow_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // One clock: drive inputs, check pre-edge state, advance the model, check registered outputs.
   task automatic step(input logic pv, input logic [IDX_W-1:0] pidx, input logic ppred,
                       input logic rv, input logic rt, input logic fl);
      logic racc, mis, pacc, was_full, was_empty;
      exp_t e;
      push_valid = pv; push_idx = pidx; push_pred = ppred;
      resolve_valid = rv; resolve_taken = rt; flush = fl;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      chk("occupancy", occupancy, mq.size());
      chk("full", full, was_full);
      chk("empty", empty, was_empty);
      chk("sat_occupancy", s_occupancy, mq.size());
      racc = rv && !was_empty;
      mis  = 1'b0;
      if (racc) begin
         mis = (rt != mq[0].pred);
         exp_q.push_back('{addr: mq[0].idx, taken: rt, mis: mis});
         void'(mq.pop_front());
      end
      if (rv && was_empty) m_under = 1'b1;
      pacc = pv && (!was_full || racc) && !fl && !mis;
      if (fl || mis) mq.delete();
      else if (pacc) mq.push_back('{idx: pidx, pred: ppred});
      if (mis) begin
         if (m_cnt16 < 65535) m_cnt16++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      @(posedge clk); #1;
      chk("bht_en", bht_en, exp_q.size() != 0);
      chk("sat_bht_en", s_bht_en, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("bht_write_addr", bht_write_addr, e.addr);
         chk("bht_was_taken", bht_was_taken, e.taken);
         chk("mispredict", mispredict, e.mis);
         chk("sat_bht_write_addr", s_bht_write_addr, e.addr);
      end else begin
         chk("mispredict_idle", mispredict, 0);
      end
      chk("mispredict_count", mispredict_count, m_cnt16);
      chk("sat_mispredict_count", s_mispredict_count, m_cnt2);
      chk("underflow_err", underflow_err, m_under);
      chk("sat_underflow_err", s_underflow_err, m_under);
   endtask

   task automatic push(input logic [IDX_W-1:0] idx, input logic pred);
      step(1'b1, idx, pred, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic resolve(input logic taken);
      step(1'b0, '0, 1'b0, 1'b1, taken, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reset is asserted with every other input active to show that it overrides them.
   task automatic do_reset();
      arst_n = 1'b0;
      push_valid = 1'b1; push_idx = 5'd17; push_pred = 1'b1;
      resolve_valid = 1'b1; resolve_taken = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      mq.delete(); exp_q.delete();
      m_under = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
      chk("rst_occupancy", occupancy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_bht_en", bht_en, 0);
      chk("rst_bht_write_addr", bht_write_addr, 0);
      chk("rst_bht_was_taken", bht_was_taken, 0);
      chk("rst_mispredict", mispredict, 0);
      chk("rst_mispredict_count", mispredict_count, 0);
      chk("rst_underflow_err", underflow_err, 0);
      chk("rst_sat_count", s_mispredict_count, 0);
      chk("rst_sat_occupancy", s_occupancy, 0);
      arst_n = 1'b1;
      push_valid = 1'b0; resolve_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      arst_n = 1'b1; push_valid = 1'b0; push_idx = '0; push_pred = 1'b0;
      resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
      m_under = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
      #2;
      do_reset();

      // Basic in-order resolve with correct predictions
      push(5'd3, 1'b1); push(5'd7, 1'b0); push(5'd9, 1'b1);
      resolve(1'b1); resolve(1'b0); resolve(1'b1);
      idle();

      // Fill, drop on full, push+resolve while full across pointer wrap
      for (int i = 0; i < DEPTH; i++) push(5'(10 + i), 1'b0);
      push(5'd14, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 5'(20 + i), 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) resolve(1'b0);
      idle();

      // Mispredict squashes younger entries and drops the same-cycle push
      push(5'd1, 1'b0); push(5'd2, 1'b1); push(5'd4, 1'b1);
      step(1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      idle();

      // Flush alone, then flush coinciding with a resolve and a push
      push(5'd6, 1'b1); push(5'd8, 1'b0); push(5'd11, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      push(5'd12, 1'b1); push(5'd13, 1'b0);
      step(1'b1, 5'd30, 1'b1, 1'b1, 1'b1, 1'b1);
      idle();

      // Resolve while empty sets the sticky underflow flag
      resolve(1'b1);
      idle(); idle();

      // Mispredict counter saturation in the narrow instance
      for (int i = 0; i < 5; i++) begin
         push(5'(i), 1'b0);
         resolve(1'b1);
      end
      idle();

      // Reset mid-stream with pending entries
      push(5'd21, 1'b1); push(5'd22, 1'b0); push(5'd23, 1'b1);
      do_reset();
      idle();
      push(5'd24, 1'b0); resolve(1'b0);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
